// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB)
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   run                 execute enable, sampled in IDLE and on the retire cycle
//   imem_req/imem_ack   instruction fetch handshake; ir_we latches the instruction
//   opcode              instr[6:0], consumed in DECODE only
//   branch_taken        ALU compare result, consumed in EXEC for branches
//   alu_src_sel         ALU B mux: 0 = rs2, 1 = immediate
//   dmem_req/dmem_we/dmem_ack  data memory handshake (dmem_we: 1 = store)
//   pc_we, pc_sel       PC update strobe and source (0 = pc+4, 1 = target)
//   rf_we, wb_sel       register write strobe and source (00 ALU, 01 mem, 10 pc+4)
//   state               current FSM state
//   retired, instret    retire pulse and wrapping retired-instruction count
//   halted, fault       terminal state flags
module core_sequencer #(
    parameter int CPU_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 ir_we,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    output logic                 alu_src_sel,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic                 retired,
    output logic [CPU_WIDTH-1:0] instret,
    output logic                 halted,
    output logic                 fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_OPIMM, C_OP, C_LOAD, C_STORE, C_BRANCH
    } class_t;

    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t                 st;
    state_t                 boundary;
    class_t                 cls;
    class_t                 dec_cls;
    logic                   dec_known;
    logic                   dec_sys;
    logic [31:0]            wait_cnt;
    logic [CPU_WIDTH-1:0]   count;
    logic                   is_branch, is_load, is_store, is_link, is_imm;
    logic                   in_body;
    logic                   retire;
    logic                   timed_out;

    always_comb begin
        dec_cls   = C_NONE;
        dec_known = 1'b1;
        dec_sys   = 1'b0;
        case (opcode)
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0010011: dec_cls = C_OPIMM;
            7'b0110011: dec_cls = C_OP;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b1110011: dec_sys = 1'b1;
            default:    dec_known = 1'b0;
        endcase
    end

    assign is_branch = (cls == C_BRANCH);
    assign is_load   = (cls == C_LOAD);
    assign is_store  = (cls == C_STORE);
    assign is_link   = (cls == C_JAL) || (cls == C_JALR);
    assign is_imm    = (cls == C_OPIMM) || (cls == C_LOAD) || (cls == C_STORE) ||
                       (cls == C_JALR)  || (cls == C_LUI)  || (cls == C_AUIPC);
    assign in_body   = (st == S_EXEC) || (st == S_MEM) || (st == S_WB);

    // The three places an instruction can finish: a branch in EXEC, an acked
    // store in MEM, or any write-back.
    assign retire    = ((st == S_EXEC) && is_branch) ||
                       ((st == S_MEM) && is_store && dmem_ack) ||
                       (st == S_WB);

    // run is only looked at on instruction boundaries.
    assign boundary  = run ? S_FETCH : S_IDLE;

    // wait_cnt counts request cycles already spent without ack; the cycle
    // that would make it reach TIMEOUT faults unless ack arrives in it.
    assign timed_out = TO_EN && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            cls      <= C_NONE;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (retire) begin
                count <= count + CPU_WIDTH'(1);
            end
            case (st)
                S_IDLE: begin
                    if (run) begin
                        st       <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        st <= S_DECODE;
                    end else if (timed_out) begin
                        st <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    if (dec_sys) begin
                        st <= S_HALT;
                    end else if (!dec_known) begin
                        st <= S_FAULT;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        st       <= boundary;
                        wait_cnt <= '0;
                    end else if (is_load || is_store) begin
                        st       <= S_MEM;
                        wait_cnt <= '0;
                    end else begin
                        st <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_store) begin
                            st       <= boundary;
                            wait_cnt <= '0;
                        end else begin
                            st <= S_WB;
                        end
                    end else if (timed_out) begin
                        st <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_WB: begin
                    st       <= boundary;
                    wait_cnt <= '0;
                end
                default: begin
                    st <= st;
                end
            endcase
        end
    end

    assign imem_req    = (st == S_FETCH);
    assign ir_we       = (st == S_FETCH) && imem_ack;
    assign dmem_req    = (st == S_MEM);
    assign dmem_we     = (st == S_MEM) && is_store;
    assign alu_src_sel = in_body && is_imm;
    assign pc_we       = retire;
    assign retired     = retire;
    assign rf_we       = (st == S_WB);
    assign pc_sel      = ((st == S_EXEC) && is_branch && branch_taken) ||
                         ((st == S_WB) && is_link);
    assign wb_sel      = (st != S_WB) ? 2'b00 :
                         is_load      ? 2'b01 :
                         is_link      ? 2'b10 : 2'b00;
    assign state       = st;
    assign instret     = count;
    assign halted      = (st == S_HALT);
    assign fault       = (st == S_FAULT);

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - scoreboard bench for core_sequencer against an instruction-level model
module tb_core_sequencer;

    localparam int CW = 4;
    localparam int TO = 8;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, OPIMM = 7'b0010011, OP = 7'b0110011,
                           LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011,
                           SYSTEM = 7'b1110011;

    localparam int EV_RET = 0, EV_HALT = 1, EV_FAULT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          imem_req, ir_we, alu_src_sel, dmem_req, dmem_we;
    logic          pc_we, pc_sel, rf_we, retired, halted, fault;
    logic [1:0]    wb_sel;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    core_sequencer #(.CPU_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .opcode(opcode), .branch_taken(branch_taken), .alu_src_sel(alu_src_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .state(state), .retired(retired), .instret(instret),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        int         iw;
        int         dw;
        bit         bt;
    } instr_t;

    typedef struct {
        int kind; int cyc; int instret; int pc_sel; int wb_sel; int rf_we;
        int alu; int icyc; int dcyc; int dwe; int irwe; int pcwe;
    } exp_t;

    instr_t     prog[$];
    exp_t       sbq[$];
    int         cyc = 0;
    int         cnt = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         viol = 0;
    logic [6:0] ret_ops [9] = '{LUI, AUIPC, JAL, JALR, OPIMM, OP, LOAD, STORE, BRANCH};

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit known_op(logic [6:0] op);
        return op inside {LUI, AUIPC, JAL, JALR, OPIMM, OP, LOAD, STORE, BRANCH};
    endfunction

    function automatic bit uses_imm(logic [6:0] op);
        return op inside {OPIMM, LOAD, STORE, JALR, LUI, AUIPC};
    endfunction

    task automatic add(logic [6:0] op, int iw, int dw, bit bt);
        instr_t p;
        p.op = op; p.iw = iw; p.dw = dw; p.bt = bt;
        prog.push_back(p);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: accumulates handshake/strobe activity and checks it whenever
    // the DUT presents an event (retire pulse, or entry into HALT/FAULT).
    initial begin
        int icnt, dcnt, ircnt, pccnt, rfcnt, ev;
        bit dwe_or, dwe_and;
        logic [2:0] prev;
        exp_t e;
        icnt = 0; dcnt = 0; ircnt = 0; pccnt = 0; rfcnt = 0;
        dwe_or = 0; dwe_and = 1; prev = 3'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                icnt = 0; dcnt = 0; ircnt = 0; pccnt = 0; rfcnt = 0;
                dwe_or = 0; dwe_and = 1;
            end else begin
                icnt += int'(imem_req); dcnt += int'(dmem_req);
                ircnt += int'(ir_we); pccnt += int'(pc_we); rfcnt += int'(rf_we);
                if (dmem_req) begin
                    dwe_or = dwe_or | dmem_we;
                    dwe_and = dwe_and & dmem_we;
                end
                if ((state == 3'd0 || state == 3'd6 || state == 3'd7) &&
                    (ir_we || pc_we || rf_we || retired || imem_req || dmem_req))
                    viol++;
                ev = retired ? EV_RET :
                     (state == 3'd6 && prev != 3'd6) ? EV_HALT :
                     (state == 3'd7 && prev != 3'd7) ? EV_FAULT : -1;
                if (ev >= 0) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_event", ev, -1);
                    end else begin
                        e = sbq.pop_front();
                        check("event_kind", ev, e.kind);
                        check("event_cycle", cyc, e.cyc);
                        check("instret", instret, e.instret);
                        check("pc_we_count", pccnt, e.pcwe);
                        check("rf_we_count", rfcnt, e.rf_we);
                        check("ir_we_count", ircnt, e.irwe);
                        check("imem_req_cycles", icnt, e.icyc);
                        check("dmem_req_cycles", dcnt, e.dcyc);
                        check("halted", halted, e.kind == EV_HALT);
                        check("fault", fault, e.kind == EV_FAULT);
                        if (e.kind == EV_RET) begin
                            check("pc_sel", pc_sel, e.pc_sel);
                            check("alu_src_sel", alu_src_sel, e.alu);
                        end
                        if (e.rf_we != 0) check("wb_sel", wb_sel, e.wb_sel);
                        if (e.dcyc > 0) begin
                            check("dmem_we_or", dwe_or, e.dwe);
                            check("dmem_we_and", dwe_and, e.dwe);
                        end
                    end
                    icnt = 0; dcnt = 0; ircnt = 0; pccnt = 0; rfcnt = 0;
                    dwe_or = 0; dwe_and = 1;
                end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                    check("missing_event", sbq[0].cyc, -1);
                    void'(sbq.pop_front());
                end
            end
            prev = state;
        end
    end

    // Runs the queued program from IDLE: the model predicts every event and
    // its cycle, and the same timing drives acks, opcode and branch_taken.
    task automatic run_burst();
        int ts[$];
        int tcur, last, end_cyc, k, i, j, m, off, len;
        bit term, mem;
        exp_t e;
        instr_t p;
        term = 0; last = 0; end_cyc = 0;
        @(posedge clk); #1;
        k = cyc; run = 1'b1; tcur = k + 1;
        for (int x = 0; x < prog.size(); x++) begin
            p = prog[x];
            e = '{default: 0};
            mem = (p.op == LOAD) || (p.op == STORE);
            e.instret = cnt; e.alu = uses_imm(p.op);
            e.irwe = 1; e.icyc = p.iw + 1;
            len = 0;
            if (p.iw >= TO) begin
                e.kind = EV_FAULT; off = TO; e.icyc = TO; e.irwe = 0;
            end else if (p.op == SYSTEM) begin
                e.kind = EV_HALT; off = p.iw + 2;
            end else if (!known_op(p.op)) begin
                e.kind = EV_FAULT; off = p.iw + 2;
            end else if (p.op == BRANCH) begin
                e.kind = EV_RET; off = p.iw + 2; e.pc_sel = p.bt; e.pcwe = 1;
            end else if (mem && p.dw >= TO) begin
                e.kind = EV_FAULT; off = p.iw + 3 + TO; e.dcyc = TO; e.dwe = (p.op == STORE);
            end else if (p.op == STORE) begin
                e.kind = EV_RET; off = p.iw + 3 + p.dw; e.dcyc = p.dw + 1; e.dwe = 1; e.pcwe = 1;
            end else if (p.op == LOAD) begin
                e.kind = EV_RET; off = p.iw + 4 + p.dw; e.dcyc = p.dw + 1;
                e.pcwe = 1; e.rf_we = 1; e.wb_sel = 1;
            end else begin
                e.kind = EV_RET; off = p.iw + 3; e.pcwe = 1; e.rf_we = 1;
                e.wb_sel = (p.op == JAL || p.op == JALR) ? 2 : 0;
                e.pc_sel = (p.op == JAL || p.op == JALR) ? 1 : 0;
            end
            if (e.kind == EV_RET) begin
                len = off + 1;
                cnt = (cnt + 1) % (1 << CW);
            end
            e.cyc = tcur + off;
            sbq.push_back(e);
            ts.push_back(tcur);
            last = x;
            if (e.kind != EV_RET) begin
                term = 1; end_cyc = e.cyc + 4;
                break;
            end
            end_cyc = e.cyc + 2;
            tcur += len;
        end
        forever begin
            i = -1;
            for (int x = 0; x <= last; x++) if (ts[x] <= k) i = x;
            opcode = 7'($urandom);
            branch_taken = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            if (i >= 0) begin
                p = prog[i];
                j = k - ts[i];
                m = p.iw + 3;
                if (j < p.iw && j < TO) imem_ack = 1'b0;
                else if (j == p.iw && p.iw < TO) imem_ack = 1'b1;
                if (p.iw < TO) begin
                    if (j == p.iw + 1) opcode = p.op;
                    if (j == p.iw + 2) branch_taken = p.bt;
                    if (p.op == LOAD || p.op == STORE) begin
                        if (j >= m && (j - m) < p.dw && (j - m) < TO) dmem_ack = 1'b0;
                        else if ((j - m) == p.dw && p.dw < TO) dmem_ack = 1'b1;
                    end
                end
            end
            run = term ? 1'b1 : (k <= ts[last]);
            if (k >= end_cyc) break;
            @(posedge clk); #1;
            k = cyc;
        end
        run = 1'b0;
        prog.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; run = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_state", state, 0);
        check("rst_instret", instret, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_strobes", {ir_we, pc_we, rf_we, retired}, 0);
        check("rst_flags", {halted, fault}, 0);
        check("rst_muxes", {pc_sel, wb_sel, alu_src_sel, dmem_we}, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            opcode = 7'($urandom);
        end
        check("idle_hold", state, 0);

        add(OP, 0, 0, 0);     add(LOAD, 0, 2, 0);  add(BRANCH, 0, 0, 1);
        add(BRANCH, 0, 0, 0); add(STORE, 1, 0, 0); add(JAL, 0, 0, 0);
        add(JALR, TO - 1, 0, 0); add(LUI, 0, 0, 0); add(AUIPC, 2, 0, 0);
        add(OPIMM, 0, 1, 0);  add(LOAD, 0, TO - 1, 0);
        run_burst();
        check("burst1_idle", state, 0);
        check("burst1_instret", instret, cnt);

        for (int n = 0; n < 12; n++)
            add(ret_ops[$urandom_range(0, 8)], $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        run_burst();
        check("wrap_instret", instret, cnt);

        add(OPIMM, 0, 0, 0); add(SYSTEM, 1, 0, 0);
        run_burst();
        check("halt_state", state, 6);
        check("halt_instret", instret, cnt);
        do_reset();

        add(7'b1111111, 0, 0, 0);
        run_burst();
        check("badop_state", state, 7);
        do_reset();

        add(OP, 0, 0, 0); add(OP, 255, 0, 0);
        run_burst();
        check("imem_timeout_state", state, 7);
        do_reset();

        add(STORE, 0, 255, 0);
        run_burst();
        check("dmem_timeout_state", state, 7);
        do_reset();

        @(posedge clk); #1;
        run = 1'b1; opcode = OP; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        check("abort_req_drop", imem_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_state", state, 0);
        check("abort_instret", instret, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sbq.size(), 0);
        check("idle_strobe_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
